// File: rtl/vid_timer_gen.sv
// Parametrised raster timer: h/v/composite sync, active-video qualifier, pixel x/y and strobes.
// Outputs are registered (1 clk after counter state); en=0 freezes counters and outputs, strobes drop.
module vid_timer_gen #(
  parameter int LINE_CLKS  = 1016,
  parameter int HSYNC_CLKS = 75,
  parameter int HACT_START = 150,
  parameter int H_PIXELS   = 200,
  parameter int PIX_DIV    = 4,
  parameter int V_LINES    = 262,
  parameter int VS_LINES   = 3,
  parameter int VACT_START = 21,
  parameter int V_ACTIVE   = 240,
  parameter int XW         = 9,
  parameter int YW         = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          interlace,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          vid_time,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          field,
  output logic          line_start,
  output logic          frame_start
);

  localparam int HW = $clog2(LINE_CLKS + 1);
  localparam int VW = $clog2(V_LINES + 2);
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(LINE_CLKS - 1);
  localparam logic [HW-1:0] H_SYNC = HW'(HSYNC_CLKS);
  localparam logic [HW-1:0] H_SERR = HW'(LINE_CLKS - HSYNC_CLKS);
  localparam logic [HW-1:0] H_ACT0 = HW'(HACT_START);
  localparam logic [HW-1:0] H_ACT1 = HW'(HACT_START + H_PIXELS * PIX_DIV);
  localparam logic [VW-1:0] V_LAST0 = VW'(V_LINES - 1);
  localparam logic [VW-1:0] V_LAST1 = VW'(V_LINES);
  localparam logic [VW-1:0] V_SYNC  = VW'(VS_LINES);
  localparam logic [VW-1:0] V_ACT0  = VW'(VACT_START);
  localparam logic [VW-1:0] V_ACT1  = VW'(VACT_START + V_ACTIVE);
  localparam logic [PW-1:0] P_LAST  = PW'(PIX_DIV - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          r_field;
  logic          r_mode;
  logic [PW-1:0] r_pix_div;

  logic          w_h_last, w_v_last, w_field_nxt;
  logic          w_hs, w_vs, w_csync_n, w_v_act, w_h_act, w_act;
  logic [VW-1:0] w_a;
  logic [YW-1:0] w_y_nxt;

  always_comb begin
    w_h_last    = (r_hcnt == H_LAST);
    // Interlaced field 1 carries the extra half-frame line.
    w_v_last    = (r_vcnt == ((r_mode && r_field) ? V_LAST1 : V_LAST0));
    w_field_nxt = r_mode ? ~r_field : 1'b0;
    w_hs        = (r_hcnt < H_SYNC);
    w_vs        = (r_vcnt < V_SYNC);
    w_csync_n   = w_vs ? ~(r_hcnt < H_SERR) : ~w_hs;
    w_v_act     = (r_vcnt >= V_ACT0) && (r_vcnt < V_ACT1);
    w_h_act     = (r_hcnt >= H_ACT0) && (r_hcnt < H_ACT1);
    w_act       = w_v_act && w_h_act;
    w_a         = r_vcnt - V_ACT0;
    w_y_nxt     = r_mode ? YW'({w_a, r_field}) : YW'(w_a);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_field <= 1'b0;
      r_mode  <= 1'b0;
    end else if (en) begin
      r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
      if (w_h_last) begin
        if (w_v_last) begin
          r_vcnt  <= '0;
          r_field <= w_field_nxt;
          // Mode only changes at a frame boundary, i.e. when entering field 0.
          if (!w_field_nxt) r_mode <= interlace;
        end else begin
          r_vcnt <= r_vcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      csync       <= 1'b1;
      vid_time    <= 1'b0;
      x           <= '0;
      y           <= '0;
      field       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r_pix_div   <= '0;
    end else if (en) begin
      hsync       <= ~w_hs;
      vsync       <= ~w_vs;
      csync       <= w_csync_n;
      vid_time    <= w_act;
      field       <= r_field;
      line_start  <= (r_hcnt == '0);
      frame_start <= (r_hcnt == '0) && (r_vcnt == '0) && !r_field;
      // Prescaler restarts on the first active clock of each line.
      if (!w_act || !vid_time) begin
        x         <= '0;
        r_pix_div <= '0;
      end else if (r_pix_div == P_LAST) begin
        x         <= x + 1'b1;
        r_pix_div <= '0;
      end else begin
        r_pix_div <= r_pix_div + 1'b1;
      end
      if ((r_hcnt == '0) && w_v_act) y <= w_y_nxt;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vid_timer_gen.sv
// Directed bench for vid_timer_gen: reduced vertical timing on the main instance, and a second
// instance with PIX_DIV=1, H_PIXELS=256, HACT_START=200.
module tb_vid_timer_gen;

  logic clk = 1'b0;
  logic rst_n, en, interlace;

  logic hsync, vsync, csync, vid_time, field, line_start, frame_start;
  logic [8:0] x, y;
  logic hsync2, vsync2, csync2, vid2, field2, ls2, fs2;
  logic [8:0] x2, y2;

  always #5 clk = ~clk;

  vid_timer_gen #(
    .V_LINES(12), .VS_LINES(3), .VACT_START(5), .V_ACTIVE(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .interlace(interlace),
    .hsync(hsync), .vsync(vsync), .csync(csync), .vid_time(vid_time),
    .x(x), .y(y), .field(field), .line_start(line_start), .frame_start(frame_start)
  );

  vid_timer_gen #(
    .LINE_CLKS(500), .HSYNC_CLKS(20), .HACT_START(200), .H_PIXELS(256), .PIX_DIV(1),
    .V_LINES(6), .VS_LINES(1), .VACT_START(2), .V_ACTIVE(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .interlace(interlace),
    .hsync(hsync2), .vsync(vsync2), .csync(csync2), .vid_time(vid2),
    .x(x2), .y(y2), .field(field2), .line_start(ls2), .frame_start(fs2)
  );

  typedef struct packed {
    logic hs, vs, cs, vt;
    logic [8:0] x, y;
    logic fld, ls, fs;
  } outs_t;

  typedef struct {
    int    c;
    logic  il;
    outs_t exp;
  } vec_t;

  vec_t  vecs[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cur = 0;
  outs_t rst_outs;

  function automatic outs_t mk(bit hs, bit vs, bit cs, bit vt, int xv, int yv, bit f, bit ls, bit fs);
    outs_t o;
    o.hs = hs; o.vs = vs; o.cs = cs; o.vt = vt;
    o.x = 9'(xv); o.y = 9'(yv);
    o.fld = f; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.hs = hsync; o.vs = vsync; o.cs = csync; o.vt = vid_time;
    o.x = x; o.y = y; o.fld = field; o.ls = line_start; o.fs = frame_start;
    return o;
  endfunction

  task automatic add(input int c, input logic il, input outs_t e);
    vec_t v;
    v.c = c; v.il = il; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input outs_t act, input outs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hs%b vs%b cs%b vt%b x%0d y%0d f%b ls%b fs%b, want hs%b vs%b cs%b vt%b x%0d y%0d f%b ls%b fs%b",
               nm, act.hs, act.vs, act.cs, act.vt, act.x, act.y, act.fld, act.ls, act.fs,
               exp.hs, exp.vs, exp.cs, exp.vt, exp.x, exp.y, exp.fld, exp.ls, exp.fs);
    end
  endtask

  // cur counts enabled edges since reset release; outputs then show counter state cur-1.
  task automatic tick();
    logic e;
    @(posedge clk);
    e = en && rst_n;
    #1;
    if (e) cur++;
  endtask

  task automatic goto_c(input int c);
    while (cur < c + 1) tick();
  endtask

  initial begin
    rst_outs = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);

    // Progressive frame 1 (12 lines x 1016 clks)
    add(0,     0, mk(0,0,0,0,  0, 0,0,1,1));
    add(1,     0, mk(0,0,0,0,  0, 0,0,0,0));
    add(74,    0, mk(0,0,0,0,  0, 0,0,0,0));
    add(75,    0, mk(1,0,0,0,  0, 0,0,0,0));
    add(940,   0, mk(1,0,0,0,  0, 0,0,0,0));
    add(941,   0, mk(1,0,1,0,  0, 0,0,0,0));
    add(1015,  0, mk(1,0,1,0,  0, 0,0,0,0));
    add(1016,  0, mk(0,0,0,0,  0, 0,0,1,0));
    add(2972,  0, mk(1,0,0,0,  0, 0,0,0,0));
    add(3048,  0, mk(0,1,0,0,  0, 0,0,1,0));
    add(3123,  0, mk(1,1,1,0,  0, 0,0,0,0));
    add(3989,  0, mk(1,1,1,0,  0, 0,0,0,0));
    add(5229,  0, mk(1,1,1,0,  0, 0,0,0,0));
    add(5230,  0, mk(1,1,1,1,  0, 0,0,0,0));
    add(5233,  0, mk(1,1,1,1,  0, 0,0,0,0));
    add(5234,  0, mk(1,1,1,1,  1, 0,0,0,0));
    add(6029,  0, mk(1,1,1,1,199, 0,0,0,0));
    add(6030,  0, mk(1,1,1,0,  0, 0,0,0,0));
    add(6096,  0, mk(0,1,0,0,  0, 1,0,1,0));
    add(10660, 0, mk(1,1,1,1, 87, 5,0,0,0));
    add(11676, 0, mk(1,1,1,0,  0, 5,0,0,0));
    add(12191, 0, mk(1,1,1,0,  0, 5,0,0,0));
    add(12192, 0, mk(0,0,0,0,  0, 5,0,1,1));
    add(12193, 0, mk(0,0,0,0,  0, 5,0,0,0));
    add(18288, 0, mk(0,1,0,0,  0, 1,0,1,0));
    // interlace raised mid-frame 2: frame 2 stays progressive
    add(24383, 1, mk(1,1,1,0,  0, 5,0,0,0));
    add(24384, 1, mk(0,0,0,0,  0, 5,0,1,1));
    add(29464, 1, mk(0,1,0,0,  0, 0,0,1,0));
    add(30480, 1, mk(0,1,0,0,  0, 2,0,1,0));
    add(36575, 1, mk(1,1,1,0,  0,10,0,0,0));
    add(36576, 1, mk(0,0,0,0,  0,10,1,1,0));
    add(41656, 1, mk(0,1,0,0,  0, 1,1,1,0));
    add(42672, 1, mk(0,1,0,0,  0, 3,1,1,0));
    add(48768, 1, mk(0,1,0,0,  0,11,1,1,0));
    add(49783, 1, mk(1,1,1,0,  0,11,1,0,0));
    add(49784, 1, mk(0,0,0,0,  0,11,0,1,1));

    rst_n = 1'b0; en = 1'b1; interlace = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_init", dut_outs(), rst_outs);
    rst_n = 1'b1;
    cur = 0;

    foreach (vecs[i]) begin
      interlace = vecs[i].il;
      goto_c(vecs[i].c);
      check($sformatf("vec%0d_c%0d", i, vecs[i].c), dut_outs(), vecs[i].exp);
    end

    // en low for 500 clks mid-pixel on an active line
    goto_c(55164);
    check("pre_freeze", dut_outs(), mk(1,1,1,1,37,0,0,0,0));
    en = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (i % 100 == 99) check($sformatf("frozen_%0d", i), dut_outs(), mk(1,1,1,1,37,0,0,0,0));
    end
    en = 1'b1;
    tick();
    check("resume_c55165", dut_outs(), mk(1,1,1,1,37,0,0,0,0));
    tick();
    check("resume_c55166", dut_outs(), mk(1,1,1,1,38,0,0,0,0));

    // freeze with the counter sitting on hcnt==0: strobe fires once on resume
    goto_c(55879);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("strobe_held_%0d", i), dut_outs(), mk(1,1,1,0,0,0,0,0,0));
    end
    en = 1'b1;
    tick();
    check("strobe_resume", dut_outs(), mk(0,1,0,0,0,2,0,1,0));
    tick();
    check("strobe_once", dut_outs(), mk(0,1,0,0,0,2,0,0,0));

    // asynchronous reset mid-cycle, interlace left high
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", dut_outs(), rst_outs);
    tick();
    tick();
    check("reset_held", dut_outs(), rst_outs);
    rst_n = 1'b1;
    cur = 0;
    goto_c(0);
    check("post_reset_c0", dut_outs(), mk(0,0,0,0,0,0,0,1,1));

    // PIX_DIV=1 instance: x 0..255, one step per clk, 256 active clks
    goto_c(1199);
    for (int i = 0; i < 258; i++) begin
      logic       ev;
      logic [8:0] ex;
      ev = (i >= 1) && (i <= 256);
      ex = ev ? 9'(i - 1) : 9'd0;
      n_chk++;
      if ({vid2, x2} !== {ev, ex}) begin
        n_fail++;
        $display("FAIL div1_c%0d: got vt%b x%0d, want vt%b x%0d", 1199 + i, vid2, x2, ev, ex);
      end
      tick();
    end

    // mode resets to progressive regardless of interlace input
    goto_c(6096);
    check("post_reset_prog_y", dut_outs(), mk(0,1,0,0,0,1,0,1,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_timer_gen.md
Name: vid_timer_gen

Overview:
- Parametrised raster timing generator for the Pong video path; successor to the fixed 16 MHz composite timer.
- Generates horizontal, vertical and composite sync, an active-video qualifier, pixel coordinates and field/line/frame strobes.
- Line length, sync widths, active window, pixel divider and line counts are parameters.
- Progressive or interlaced operation is selected at run time; the new mode takes effect only at a frame boundary.

Parameters:
LINE_CLKS, 1016, clocks per line; hcnt runs 0..LINE_CLKS-1
HSYNC_CLKS, 75, horizontal sync pulse width in clocks
HACT_START, 150, hcnt of first active clock
H_PIXELS, 200, active pixels per line
PIX_DIV, 4, clocks per pixel (>=1)
V_LINES, 262, lines in field 0 or in a progressive frame; interlaced field 1 has V_LINES+1
VS_LINES, 3, vertical sync lines at the start of every field (vcnt 0..VS_LINES-1)
VACT_START, 21, vcnt of first active line
V_ACTIVE, 240, active lines per field
XW, 9, width of x
YW, 9, width of y

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; low freezes all counters and holds all outputs
interlace  in  1  mode request: 1 = interlaced, 0 = progressive
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
csync  out  1  active-low composite sync, serrated during vertical sync
vid_time  out  1  active-video qualifier
x  out  XW  pixel column
y  out  YW  pixel row
field  out  1  current field; always 0 in progressive mode
line_start  out  1  one-clock strobe at hcnt==0
frame_start  out  1  one-clock strobe at hcnt==0, vcnt==0, field==0

Behaviour:
- Reset (asynchronous, rst_n low):
  - hcnt=0, vcnt=0, pix_div=0, field=0, mode=0.
  - hsync=vsync=csync=1.
  - vid_time=0, x=0, y=0, line_start=0, frame_start=0.
- Counting, only when en=1; en=0 holds everything:
  - hcnt increments and wraps LINE_CLKS-1 -> 0.
  - On the hcnt wrap, vcnt increments.
  - vcnt wraps to 0 after the last line of the field. That is V_LINES-1 for progressive or field 0, and V_LINES for interlaced field 1.
- Field and mode:
  - At each vcnt wrap, field toggles if mode=1; otherwise field=0.
  - mode is loaded from interlace only on the wrap into field 0 (frame boundary).
  - A mid-frame change of interlace has no effect until that wrap.
- Latency: all outputs are registered and reflect the counter state of the previous cycle (1 clk latency).
- hsync: low when hcnt < HSYNC_CLKS.
- vsync: low when vcnt < VS_LINES.
- csync:
  - When vcnt >= VS_LINES, equals hsync.
  - When vcnt < VS_LINES (serrated broad pulses), low for hcnt < LINE_CLKS-HSYNC_CLKS and high for the last HSYNC_CLKS clocks of the line.
- vid_time: 1 iff both hold:
  - VACT_START <= vcnt < VACT_START+V_ACTIVE;
  - HACT_START <= hcnt < HACT_START+H_PIXELS*PIX_DIV.
- x:
  - 0 whenever vid_time is 0.
  - During active clocks, x = (hcnt-HACT_START)/PIX_DIV.
  - Implemented with a pix_div prescaler cleared outside the active window, not a divider.
  - The last pixel of a line is H_PIXELS-1.
- y, with a = vcnt-VACT_START:
  - Progressive: y = a.
  - Interlaced: y = 2a+field.
  - y is truncated to YW bits.
  - y holds its last value outside active lines and is reloaded at hcnt==0 of each active line.
- Strobes: line_start and frame_start are high for exactly one clk. They are suppressed while en=0 and fire once when counting resumes.
- Boundary conditions:
  - HACT_START+H_PIXELS*PIX_DIV must be <= LINE_CLKS.
  - VACT_START+V_ACTIVE must be <= V_LINES.
  - VS_LINES must be < VACT_START.
  - Violations are a configuration error; no runtime check is required.
- Reset asserted mid-line immediately returns all outputs to reset values. After release, counting restarts at hcnt=0, vcnt=0, field 0, and mode is re-sampled at the first frame wrap.

Test Plan:
1. Reset, en=1, interlace=0, defaults:
   - hsync low for 75 clks every 1016.
   - line_start period 1016.
   - frame_start period 262*1016=266192 clks.
   - field stays 0.
2. Active window, progressive, line vcnt=21:
   - vid_time rises 1 clk after hcnt=150 and lasts 800 clks.
   - x steps 0..199, changing every 4 clks.
   - y=0; on vcnt=260, y=239.
   - vid_time=0 on vcnt=261.
3. Interlace:
   - interlace=1 asserted mid-frame: no change until the next frame wrap.
   - After the wrap, fields alternate 262/263 lines and the frame is 525 lines.
   - First active line: y=0 in field 0, y=1 in field 1.
4. Vertical sync, vcnt 0..2:
   - vsync low.
   - csync low for 941 clks, then high for 75 clks on each line.
   - On vcnt=3, csync==hsync.
5. en and reset:
   - en=0 for 500 clks mid-line: all outputs frozen; resumes without skipped counts.
   - rst_n pulsed low mid-line: outputs return to reset values asynchronously, before the next clk edge.
6. Override parameters PIX_DIV=1, H_PIXELS=256, HACT_START=200:
   - x runs 0..255 with one increment per clk.
   - vid_time lasts 256 clks per active line.
